// File: rtl/cpu_gen2_pkg.sv
// Shared encodings for the cpu_gen2 multicycle core:
// opcodes, FSM states and instruction field positions.
package cpu_gen2_pkg;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_PUSH = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC;
  localparam logic [3:0] OP_STOP = 4'hF;

  localparam logic [3:0] IMM_MARKER = 4'b1000;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_OPX_IND  = 4'd2;
  localparam logic [3:0] S_OPY      = 4'd3;
  localparam logic [3:0] S_OPY_IND  = 4'd4;
  localparam logic [3:0] S_OPZ      = 4'd5;
  localparam logic [3:0] S_OPZ_IND  = 4'd6;
  localparam logic [3:0] S_EXEC     = 4'd7;
  localparam logic [3:0] S_WB_IND   = 4'd8;
  localparam logic [3:0] S_IN_WAIT  = 4'd9;
  localparam logic [3:0] S_OUT_WAIT = 4'd10;
  localparam logic [3:0] S_STACK    = 4'd11;
  localparam logic [3:0] S_STOP_SEQ = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int X_HI  = 11;
  localparam int X_LO  = 8;
  localparam int Y_HI  = 7;
  localparam int Y_LO  = 4;
  localparam int Z_HI  = 3;
  localparam int Z_LO  = 0;
  localparam int IND_BIT = 3;

endpackage

// File: rtl/cpu_gen2_alu.sv
// Combinational unsigned ADD/SUB/MUL/DIV, modulo 2**DATA_WIDTH;
// division by zero yields all-ones.
module alu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MUL: y = a * b;
      OP_DIV: y = (b == '0) ? '1 : a / b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_gen2_reg.sv
// Plain enabled register with asynchronous reset value,
// used for PC, SP and IR.
module cpu_gen2_reg #(
  parameter int unsigned W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cpu_gen2.sv
// Multicycle memory-to-memory CPU with IN/OUT handshakes and stack.
// Optional stack bounds checking: define CPU_STACK_CHECK_EN.
module cpu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned START_PC    = 8,
  parameter int unsigned STACK_TOP   = 2**ADDR_WIDTH-1,
  parameter int unsigned STACK_LIMIT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  halted,
  output logic                  fault
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [AW-1:0] PC_RST = AW'(START_PC);
  localparam logic [AW-1:0] SP_RST = AW'(STACK_TOP);

  logic [3:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, sp_q, sp_d;
  logic [AW-1:0] xa_q, xa_d;
  logic [15:0]   ir_q, inst;
  logic [DW-1:0] a_q, a_d, out_q, out_d, alu_y;
  logic          out_valid_q, out_valid_d;
  logic          halted_q, halted_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    op, fx, fy, fz, sf;
  logic [AW-1:0] ind, xe;
  logic          uses_x, go_x, stk_fault;

  function automatic logic [AW-1:0] ext3(input logic [2:0] f);
    return AW'(f);
  endfunction

  // During DECODE the instruction is still on mem_in
  assign inst = (state_q == S_DECODE) ? mem_in[15:0] : ir_q;
  assign op   = inst[OP_HI:OP_LO];
  assign fx   = inst[X_HI:X_LO];
  assign fy   = inst[Y_HI:Y_LO];
  assign fz   = inst[Z_HI:Z_LO];
  assign ind  = mem_in[AW-1:0];
  assign xe   = (state_q == S_OPX_IND) ? ind : ext3(fx[2:0]);
  assign sf   = (idx_q == 2'd0) ? fx : (idx_q == 2'd1) ? fy : fz;

  assign uses_x = op inside {OP_MOV, OP_ADD, OP_SUB, OP_MUL,
                             OP_DIV, OP_IN, OP_OUT, OP_JZ,
                             OP_PUSH, OP_POP};

`ifdef CPU_STACK_CHECK_EN
  localparam logic [AW-1:0] SP_LIM = AW'(STACK_LIMIT);
  logic fault_q, fault_d;
  assign stk_fault = (op == OP_PUSH) ? (sp_q < SP_LIM)
                                     : (sp_q == SP_RST);
  assign fault = fault_q;
`else
  logic unused_lim;
  assign unused_lim = ^STACK_LIMIT;
  assign stk_fault = 1'b0;
  assign fault = 1'b0;
`endif

  alu_gen2 #(.DATA_WIDTH(DW)) u_alu (
    .op(op),
    .a (a_q),
    .b (mem_in),
    .y (alu_y)
  );

  cpu_gen2_reg #(.W(AW), .RST_VAL(PC_RST)) u_pc (
    .clk(clk), .rst(rst), .en(1'b1), .d(pc_d), .q(pc_q)
  );

  cpu_gen2_reg #(.W(AW), .RST_VAL(SP_RST)) u_sp (
    .clk(clk), .rst(rst), .en(1'b1), .d(sp_d), .q(sp_q)
  );

  cpu_gen2_reg #(.W(16), .RST_VAL(16'h0)) u_ir (
    .clk(clk), .rst(rst), .en(state_q == S_DECODE),
    .d(mem_in[15:0]), .q(ir_q)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    xa_d        = xa_q;
    a_d         = a_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    idx_d       = idx_q;
    go_x        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
`ifdef CPU_STACK_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        pc_d     = pc_q + 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (uses_x && fx[IND_BIT]) begin
          mem_addr = ext3(fx[2:0]);
          state_d  = S_OPX_IND;
        end else if (uses_x) begin
          go_x = 1'b1;
        end else if (op == OP_JMP) begin
          mem_addr = pc_q;
          state_d  = S_EXEC;
        end else if (op == OP_STOP) begin
          idx_d   = 2'd0;
          state_d = S_STOP_SEQ;
        end
      end
      S_OPX_IND: begin
        if (op == OP_STOP) begin
          mem_addr = ind;
          state_d  = S_EXEC;
        end else begin
          go_x = 1'b1;
        end
      end
      S_OPY_IND: begin
        mem_addr = ind;
        state_d  = (op == OP_MOV) ? S_EXEC : S_OPZ;
      end
      S_OPY: begin
        a_d      = mem_in;
        mem_addr = pc_q;
        pc_d     = pc_q + 1'b1;
        state_d  = S_EXEC;
      end
      S_OPZ: begin
        a_d      = mem_in;
        mem_addr = ext3(fz[2:0]);
        state_d  = fz[IND_BIT] ? S_OPZ_IND : S_EXEC;
      end
      S_OPZ_IND: begin
        mem_addr = ind;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (op)
          OP_MOV: begin
            mem_we   = 1'b1;
            mem_addr = xa_q;
            mem_data = mem_in;
          end
          OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
            mem_we   = 1'b1;
            mem_addr = xa_q;
            mem_data = alu_y;
          end
          OP_OUT, OP_STOP: begin
            out_d       = mem_in;
            out_valid_d = 1'b1;
            state_d     = S_OUT_WAIT;
          end
          OP_JMP: pc_d = ind;
          OP_JZ: if (a_q == '0) pc_d = ind;
          default: ;
        endcase
      end
      S_WB_IND: begin
        mem_we   = 1'b1;
        mem_addr = xa_q;
        mem_data = mem_in;
        state_d  = S_FETCH;
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          mem_we   = 1'b1;
          mem_addr = xa_q;
          mem_data = in;
          state_d  = S_FETCH;
        end
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (op == OP_STOP) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_STOP_SEQ;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_STACK: begin
        if (stk_fault) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (op == OP_PUSH) begin
          mem_we   = 1'b1;
          mem_addr = sp_q;
          mem_data = mem_in;
          sp_d     = sp_q - 1'b1;
          state_d  = S_FETCH;
        end else begin
          mem_addr = sp_q + 1'b1;
          sp_d     = sp_q + 1'b1;
          state_d  = S_WB_IND;
        end
      end
      S_STOP_SEQ: begin
        if (idx_q == 2'd3) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (sf == 4'b0000) begin
          idx_d = idx_q + 1'b1;
        end else begin
          mem_addr = ext3(sf[2:0]);
          state_d  = sf[IND_BIT] ? S_OPX_IND : S_EXEC;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // Work that follows once the X operand address is resolved
    if (go_x) begin
      xa_d = xe;
      if (op == OP_MOV && fz == IMM_MARKER) begin
        mem_addr = pc_q;
        pc_d     = pc_q + 1'b1;
        state_d  = S_EXEC;
      end else if (op inside {OP_MOV, OP_ADD, OP_SUB,
                              OP_MUL, OP_DIV}) begin
        mem_addr = ext3(fy[2:0]);
        if (fy[IND_BIT]) state_d = S_OPY_IND;
        else if (op == OP_MOV) state_d = S_EXEC;
        else state_d = S_OPZ;
      end else if (op == OP_IN) begin
        state_d = S_IN_WAIT;
      end else if (op == OP_OUT) begin
        mem_addr = xe;
        state_d  = S_EXEC;
      end else if (op == OP_JZ) begin
        mem_addr = xe;
        state_d  = S_OPY;
      end else if (op == OP_PUSH) begin
        mem_addr = xe;
        state_d  = S_STACK;
      end else begin
        state_d = S_STACK;
      end
    end

`ifdef CPU_STACK_CHECK_EN
    if (state_q == S_STACK && stk_fault) fault_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      xa_q        <= '0;
      a_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      xa_q        <= xa_d;
      a_q         <= a_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      idx_q       <= idx_d;
    end
  end

`ifdef CPU_STACK_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`endif

  assign pc        = pc_q;
  assign sp        = sp_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign in_ready  = (state_q == S_IN_WAIT);
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed bench for cpu_gen2 with a 64-word synchronous memory
// model and hand-computed expected results.
module tb_cpu_gen2;

  logic        clk;
  logic        rst;
  logic [15:0] mem_in;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  pc;
  logic [5:0]  sp;
  logic        halted;
  logic        fault;

  logic [15:0] mem [64];
  int checks = 0;
  int errors = 0;

  cpu_gen2 dut (
    .clk(clk), .rst(rst),
    .mem_in(mem_in), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .sp(sp), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic flag(input int sel);
    case (sel)
      0: return out_valid;
      1: return halted;
      2: return in_ready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_flag(input int sel, input string tag);
    int n = 0;
    while (!flag(sel) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(flag(sel)), 32'd1);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic start();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int c;
  int n;
  int we_seen;
  logic [15:0] got_v [4];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd8);
    chk("rst_sp", 32'(sp), 32'd63);
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_iready", 32'(in_ready), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);

    // MOV 1,#5; MOV 2,#3; SUB 3,1,2; OUT 3; STOP
    hold_reset();
    mem[8] = 16'h0108; mem[9] = 16'h0005;
    mem[10] = 16'h0208; mem[11] = 16'h0003;
    mem[12] = 16'h2312; mem[13] = 16'h8300;
    mem[14] = 16'hF000;
    start();
    wait_flag(0, "sub_ovalid");
    chk("sub_out", 32'(dout), 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sub_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("sub_clear", 32'(out_valid), 32'd0);
    wait_flag(1, "sub_halt");
    chk("sub_mem3", 32'(mem[3]), 32'd2);

    // IN 1; OUT 1; STOP
    hold_reset();
    mem[8] = 16'h7100; mem[9] = 16'h8100; mem[10] = 16'hF000;
    start();
    wait_flag(2, "in_ready");
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    chk("in_nowe", 32'(we_seen), 32'd0);
    chk("in_pc", 32'(pc), 32'd9);
    din = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_mem1", 32'(mem[1]), 32'h1234);
    wait_flag(0, "in_ovalid");
    chk("in_out", 32'(dout), 32'h1234);
    out_ready = 1'b1;
    wait_flag(1, "in_halt");

    // MOV (4),5 then ADD 7,(4),(5)
    hold_reset();
    mem[3] = 16'h0100; mem[4] = 16'h0006; mem[5] = 16'h0003;
    mem[8] = 16'h0C50; mem[9] = 16'h17CD; mem[10] = 16'hF000;
    start();
    c = 1;
    while (!mem_we && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("movind_cyc", 32'(c), 32'd4);
    chk("movind_addr", 32'(mem_addr), 32'd6);
    wait_flag(1, "ind_halt");
    chk("movind_mem6", 32'(mem[6]), 32'd3);
    chk("addind_mem7", 32'(mem[7]), 32'h0103);

    // PUSH 1; PUSH 2; POP 3; POP 4
    hold_reset();
    mem[1] = 16'd7; mem[2] = 16'd9;
    mem[8] = 16'hB100; mem[9] = 16'hB200;
    mem[10] = 16'hC300; mem[11] = 16'hC400; mem[12] = 16'hF000;
    start();
    wait_flag(1, "stk_halt");
    chk("stk_mem3", 32'(mem[3]), 32'd9);
    chk("stk_mem4", 32'(mem[4]), 32'd7);
    chk("stk_mem63", 32'(mem[63]), 32'd7);
    chk("stk_mem62", 32'(mem[62]), 32'd9);
    chk("stk_sp", 32'(sp), 32'd63);

    // JZ 1 taken / not taken
    for (int k = 0; k < 2; k++) begin
      hold_reset();
      mem[1] = 16'(k);
      mem[8] = 16'hA100; mem[9] = 16'd20;
      mem[10] = 16'hF000; mem[20] = 16'hF000;
      start();
      repeat (4) @(negedge clk);
      chk(k == 0 ? "jz_taken" : "jz_fall", 32'(pc),
          k == 0 ? 32'd20 : 32'd10);
      wait_flag(1, "jz_halt");
    end

    // Arithmetic: DIV by zero, DIV, MUL, ADD wrap, SUB wrap
    hold_reset();
    mem[0] = 16'hFFFF; mem[1] = 16'd100; mem[5] = 16'd7;
    mem[8] = 16'h4312; mem[9] = 16'h4415; mem[10] = 16'h3615;
    mem[11] = 16'h1701; mem[12] = 16'h2251; mem[13] = 16'hF000;
    start();
    wait_flag(1, "alu_halt");
    chk("div0", 32'(mem[3]), 32'hFFFF);
    chk("div", 32'(mem[4]), 32'd14);
    chk("mul", 32'(mem[6]), 32'h02BC);
    chk("add_wrap", 32'(mem[7]), 32'h0063);
    chk("sub_wrap", 32'(mem[2]), 32'hFFA3);

    // JMP 16; STOP 1,0,3
    hold_reset();
    mem[1] = 16'h0011; mem[3] = 16'h0033;
    mem[8] = 16'h9000; mem[9] = 16'd16; mem[16] = 16'hF103;
    out_ready = 1'b1;
    start();
    n = 0;
    c = 0;
    while (!halted && c < 300) begin
      @(negedge clk);
      c++;
      if (out_valid && out_ready) begin
        if (n < 4) got_v[n] = dout;
        n++;
      end
    end
    chk("stop_halt", 32'(halted), 32'd1);
    chk("stop_count", 32'(n), 32'd2);
    chk("stop_v0", 32'(got_v[0]), 32'h0011);
    chk("stop_v1", 32'(got_v[1]), 32'h0033);

    // Reset asserted while waiting in OUT_WAIT
    hold_reset();
    mem[1] = 16'h0055; mem[8] = 16'h8100;
    start();
    wait_flag(0, "mid_ovalid");
    rst = 1'b1;
    #1;
    chk("mid_ovalid0", 32'(out_valid), 32'd0);
    chk("mid_pc", 32'(pc), 32'd8);

`ifdef CPU_STACK_CHECK_EN
    // POP at reset SP must fault
    hold_reset();
    mem[1] = 16'h00AA; mem[8] = 16'hC100; mem[9] = 16'hF000;
    start();
    wait_flag(1, "flt_halt");
    chk("flt_fault", 32'(fault), 32'd1);
    chk("flt_sp", 32'(sp), 32'd63);
    chk("flt_mem1", 32'(mem[1]), 32'h00AA);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
